regfile_write_arbiter: RTL

- Shares the single write port of the 32x32 register bank between two writeback requesters: requester 0 (ALU result) and requester 1 (memory load data).
- Each requester has a 1-entry holding slot behind a valid/ready handshake.
- Each cycle, one pending slot is issued as a registered write (address, data, enable) driven straight into the register bank write port.
- Also exports a pending-write mask for hazard detection.

---
 rtl/regfile_write_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-bank write port between
// the ALU (requester 0) and the memory load path (requester 1). Each requester
// owns a one-entry holding slot. One slot is issued per cycle as a registered
// write. A pending-write mask is exported for hazard detection.
// Optional feature macro: REGFILE_BYPASS_EN adds two combinational lookup
// ports that forward the youngest pending or in-flight value for an address.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       aluValid,
    input  logic [ADDR_WIDTH-1:0]      aluAddr,
    input  logic [DATA_WIDTH-1:0]      aluData,
    output logic                       aluReady,
    input  logic                       memValid,
    input  logic [ADDR_WIDTH-1:0]      memAddr,
    input  logic [DATA_WIDTH-1:0]      memData,
    output logic                       memReady,
    output logic [ADDR_WIDTH-1:0]      registerAddressC,
    output logic [DATA_WIDTH-1:0]      writeData,
    output logic                       writeEnable,
    output logic [(2**ADDR_WIDTH)-1:0] pendingMask,
    output logic                       idle
`ifdef REGFILE_BYPASS_EN
    ,
    input  logic [ADDR_WIDTH-1:0]      lookupAddrA,
    input  logic [ADDR_WIDTH-1:0]      lookupAddrB,
    output logic                       bypassHitA,
    output logic                       bypassHitB,
    output logic [DATA_WIDTH-1:0]      bypassDataA,
    output logic [DATA_WIDTH-1:0]      bypassDataB
`endif
);

    // Requester inputs gathered into arrays so both slots share one code path.
    logic                  in_valid [2];
    logic [ADDR_WIDTH-1:0] in_addr  [2];
    logic [DATA_WIDTH-1:0] in_data  [2];

    assign in_valid[0] = aluValid;
    assign in_addr[0]  = aluAddr;
    assign in_data[0]  = aluData;
    assign in_valid[1] = memValid;
    assign in_addr[1]  = memAddr;
    assign in_data[1]  = memData;

    // Slot state. age_q=1 means the memory slot is the older one.
    // prefer_q names the requester that wins the next different-address tie.
    logic [1:0]            full_q, full_d;
    logic [ADDR_WIDTH-1:0] addr_q [2];
    logic [ADDR_WIDTH-1:0] addr_d [2];
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [DATA_WIDTH-1:0] data_d [2];
    logic                  age_q, age_d;
    logic                  prefer_q, prefer_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [1:0] grant;
    logic [1:0] ready;
    logic [1:0] fill;

    // Grant is a function of slot state, age and pointer only, so ready never
    // depends on a valid input.
    always_comb begin
        grant = 2'b00;
        case (full_q)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (addr_q[0] == addr_q[1]) begin
                    grant = age_q ? 2'b10 : 2'b01;
                end else begin
                    grant = prefer_q ? 2'b10 : 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    assign ready    = ~full_q | grant;
    assign aluReady = ready[0];
    assign memReady = ready[1];

    // A handover to register 0 completes the handshake but never fills a slot.
    assign fill[0] = in_valid[0] & ready[0] & (in_addr[0] != '0);
    assign fill[1] = in_valid[1] & ready[1] & (in_addr[1] != '0);

    // Next-state: slot refill/drain, age tracking, pointer and output register.
    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        for (int i = 0; i < 2; i++) begin
            if (fill[i]) begin
                full_d[i] = 1'b1;
                addr_d[i] = in_addr[i];
                data_d[i] = in_data[i];
            end else if (grant[i]) begin
                full_d[i] = 1'b0;
            end
        end

        // The slot that stays full while the other fills becomes the older one;
        // simultaneous fills treat memory as older.
        age_d = age_q;
        if (fill[0] && fill[1]) begin
            age_d = 1'b1;
        end else if (fill[0] && full_q[1] && !grant[1]) begin
            age_d = 1'b1;
        end else if (fill[1] && full_q[0] && !grant[0]) begin
            age_d = 1'b0;
        end

        prefer_d = prefer_q;
        if (grant[0]) begin
            prefer_d = 1'b1;
        end else if (grant[1]) begin
            prefer_d = 1'b0;
        end

        we_d    = |grant;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (grant[1]) begin
            waddr_d = addr_q[1];
            wdata_d = data_q[1];
        end else if (grant[0]) begin
            waddr_d = addr_q[0];
            wdata_d = data_q[0];
        end
    end

    // State registers with synchronous active-low reset; reset drops handshakes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            full_q   <= 2'b00;
            addr_q   <= '{default: '0};
            data_q   <= '{default: '0};
            age_q    <= 1'b0;
            prefer_q <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            full_q   <= full_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            age_q    <= age_d;
            prefer_q <= prefer_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign writeEnable      = we_q;
    assign registerAddressC = waddr_q;
    assign writeData        = wdata_q;
    assign idle             = !full_q[0] && !full_q[1] && !we_q;

    // Pending mask decoded from the slots only; bit 0 is tied low.
    genvar gi;
    generate
        for (gi = 0; gi < 2**ADDR_WIDTH; gi++) begin : g_mask
            if (gi == 0) begin : g_zero
                assign pendingMask[gi] = 1'b0;
            end else begin : g_bit
                assign pendingMask[gi] =
                    (full_q[0] && (addr_q[0] == ADDR_WIDTH'(gi))) ||
                    (full_q[1] && (addr_q[1] == ADDR_WIDTH'(gi)));
            end
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    logic [ADDR_WIDTH-1:0] lk_addr  [2];
    logic                  lk_hit   [2];
    logic [DATA_WIDTH-1:0] lk_data  [2];

    assign lk_addr[0] = lookupAddrA;
    assign lk_addr[1] = lookupAddrB;

    // Youngest match wins: younger slot, then older slot, then the output register.
    always_comb begin
        logic [1:0] slot_hit;
        logic       out_hit;
        int         young;
        int         old;
        young = age_q ? 0 : 1;
        old   = age_q ? 1 : 0;
        for (int l = 0; l < 2; l++) begin
            slot_hit[0] = full_q[0] && (addr_q[0] == lk_addr[l]);
            slot_hit[1] = full_q[1] && (addr_q[1] == lk_addr[l]);
            out_hit     = we_q && (waddr_q == lk_addr[l]);
            lk_hit[l]   = 1'b0;
            lk_data[l]  = '0;
            if (lk_addr[l] != '0) begin
                if (slot_hit[young]) begin
                    lk_hit[l]  = 1'b1;
                    lk_data[l] = data_q[young];
                end else if (slot_hit[old]) begin
                    lk_hit[l]  = 1'b1;
                    lk_data[l] = data_q[old];
                end else if (out_hit) begin
                    lk_hit[l]  = 1'b1;
                    lk_data[l] = wdata_q;
                end
            end
        end
    end

    assign bypassHitA  = lk_hit[0];
    assign bypassHitB  = lk_hit[1];
    assign bypassDataA = lk_data[0];
    assign bypassDataB = lk_data[1];
`endif

endmodule
